// File: rtl/rf_512x32_arb_pkg.sv
// Shared types for the 512x32 register-file arbiter: request/write-port records,
// init sequencer states and the macro geometry.
package rf_arb_pkg;

    localparam int RfDepth = 512;
    localparam int RfDW    = 32;
    localparam int RfAW    = $clog2(RfDepth);

    // Records are sized for the default macro geometry (AW = 9, DW = 32).
    typedef struct packed {
        logic            we;
        logic [RfAW-1:0] addr;
        logic [RfDW-1:0] wdata;
        logic [RfDW-1:0] wmask;
    } rf_req_t;

    typedef struct packed {
        logic            wen;
        logic [RfAW-1:0] waddr;
        logic [RfDW-1:0] wdata;
        logic [RfDW-1:0] wmask;
    } rf_wport_t;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } init_state_e;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins the
// next contended cycle and moves to the loser after every contention.
module rf_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end
            default: gnt_o = 2'b00;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_512x32_arb.sv
// Two-requester front end for the 512x32 1R1W bit-masked register-file macro,
// with independent read/write arbitration and a zero-fill init sequencer.
module rf_512x32_arb
    import rf_arb_pkg::*;
#(
    parameter int AW          = 9,
    parameter int DW          = 32,
    parameter bit InitOnReset = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         req_i,
    input  logic [1:0]         we_i,
    input  logic [1:0][AW-1:0] addr_i,
    input  logic [1:0][DW-1:0] wdata_i,
    input  logic [1:0][DW-1:0] wmask_i,
    output logic [1:0]         gnt_o,
    output logic [1:0]         rvalid_o,
    output logic [DW-1:0]      rdata_o,
    input  logic               init_i,
    output logic               init_busy_o,
    output logic               init_done_o,
    output logic               rf_wen_o,
    output logic [AW-1:0]      rf_waddr_o,
    output logic [DW-1:0]      rf_wdata_o,
    output logic [DW-1:0]      rf_wmask_o,
    output logic               rf_ren_o,
    output logic [AW-1:0]      rf_raddr_o,
    input  logic [DW-1:0]      rf_rdata_i
);

    localparam logic [AW:0]   LastAddr   = (AW+1)'(2**AW - 1);
    localparam init_state_e   ResetState = InitOnReset ? INIT : IDLE;

    init_state_e      state_q, state_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [1:0]       rvalid_q;
    logic             idle, filling, wr_go;
    logic [1:0]       wr_cand, rd_cand, wr_gnt, rd_gnt;
    rf_req_t [1:0]    rq;
    rf_req_t          wr_req;
    rf_wport_t        wport;

    // The reset state may be INIT, yet every output must read 0 while reset is
    // held, so rst_ni also qualifies the combinational outputs.
    assign idle    = rst_ni && (state_q == IDLE);
    assign filling = rst_ni && (state_q == INIT);

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            rq[n] = '{we: we_i[n], addr: addr_i[n], wdata: wdata_i[n], wmask: wmask_i[n]};
        end
    end

    assign wr_cand = idle ? (req_i & we_i) : 2'b00;

    rf_rr_arb2 u_wr_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (wr_cand),
        .gnt_o  (wr_gnt)
    );

    assign wr_go  = |wr_gnt;
    assign wr_req = wr_gnt[1] ? rq[1] : rq[0];

    // A read hitting the address written this cycle stands down and retries.
    always_comb begin
        rd_cand = 2'b00;
        for (int n = 0; n < 2; n++) begin
            rd_cand[n] = idle && req_i[n] && !we_i[n]
                         && !(wr_go && (addr_i[n] == wr_req.addr));
        end
    end

    rf_rr_arb2 u_rd_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (rd_cand),
        .gnt_o  (rd_gnt)
    );

    assign gnt_o = wr_gnt | rd_gnt;

    always_comb begin
        wport = '0;
        if (filling) begin
            wport = '{wen: 1'b1, waddr: cnt_q[AW-1:0], wdata: '0, wmask: '1};
        end else if (wr_go) begin
            wport = '{wen: 1'b1, waddr: wr_req.addr, wdata: wr_req.wdata, wmask: wr_req.wmask};
        end
    end

    assign rf_wen_o   = wport.wen;
    assign rf_waddr_o = wport.waddr;
    assign rf_wdata_o = wport.wdata;
    assign rf_wmask_o = wport.wmask;

    assign rf_ren_o   = |rd_gnt;
    assign rf_raddr_o = rd_gnt[1] ? addr_i[1] : (rd_gnt[0] ? addr_i[0] : '0);

    assign rvalid_o    = rvalid_q;
    assign rdata_o     = (|rvalid_q) ? rf_rdata_i : '0;
    assign init_busy_o = filling;
    assign init_done_o = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                if (init_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ResetState;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            rvalid_q <= rd_gnt;
        end
    end

endmodule
